keyboard_state_decoder: RTL and testbench
=========================================

// Module: keyboard_state_decoder
// PURPOSE
//  Converts the PS/2 Set-2 scancode byte stream into the held-key vector inputStateStorage consumed by the master FSM.
//  Tracks the make, break (F0) and extended (E0) prefixes, and maps each scancode to a key index.
//  Holds one bit per key: 1 while the key is held.
//  Emits one-cycle press/release pulse vectors for the recorder and the note generators.
//  Sits between the PS/2 byte receiver and MasterFSM / the audio datapath.
// PARAMETERS
//  NUM_KEYS        `NUMBEROFKEYBOARDINPUTS  width of the key vector
//  TIMEOUT_CYCLES  500000                   idle cycles after a prefix byte before the prefix is dropped (10 ms @ 50 MHz)
// PORTS
//  clk                input   1         system clock, rising edge
//  resetn             input   1         asynchronous reset, active-low
//  ps2ByteValid       input   1         one-cycle strobe: ps2Byte holds a complete received byte
//  ps2Byte            input   8         received scancode byte
//  inputStateStorage  output  NUM_KEYS  held-key vector, bit k = key index k held
//  keyPressPulse      output  NUM_KEYS  one-cycle pulse on the 0->1 transition of a bit
//  keyReleasePulse    output  NUM_KEYS  one-cycle pulse on the 1->0 transition of a bit
//  unknownCode        output  1         one-cycle pulse: a complete code had no mapping
// BEHAVIOUR
//  Reset (resetn low, async):
//   - all outputs 0; prefix FSM in IDLE; timeout counter 0.
//  Prefix FSM states and transitions (evaluated only on cycles with ps2ByteValid=1):
//   - IDLE:     E0->EXT, F0->BRK, else complete code (make, normal table) -> IDLE
//   - EXT:      F0->EXTBRK, else complete code (make, extended table) -> IDLE
//   - BRK:      complete code (break, normal table) -> IDLE
//   - EXTBRK:   complete code (break, extended table) -> IDLE
//   - E0 received in BRK/EXTBRK, or F0 received in EXTBRK: protocol error -> IDLE, no key change, no pulse.
//  Ignored bytes in any state:
//   - AA, FA, EE, FE, 00, FF: keyboard status/ack bytes; no key change.
//   - E1: Pause key; ignored, FSM unchanged.
//  Latency:
//   - byte strobed in cycle N -> inputStateStorage and pulses updated at the edge ending cycle N, visible in cycle N+1.
//   - pulses are high exactly one cycle.
//  Make code:
//   - mapped index k sets bit k.
//   - keyPressPulse[k] fires only if bit k was 0; typematic repeats give no pulse.
//  Break code:
//   - clears bit k.
//   - keyReleasePulse[k] fires only if bit k was 1.
//  Unmapped complete code:
//   - unknownCode pulses; vector unchanged.
//  Timeout:
//   - counter runs only in EXT/BRK/EXTBRK; clears on every valid byte.
//   - at TIMEOUT_CYCLES-1 with no valid byte the FSM returns to IDLE.
//   - a valid byte in the expiry cycle wins: it is decoded with the current prefix.
//  Only one key changes per byte, so at most one pulse bit is set in any cycle.
//  Reset mid-sequence discards any partial prefix; all keys read released.
// STRUCTURE
//  DefineMacros.vh holds the shared constants:
//   - key index macros (`keySpacebar, `keyBackslash, `keyR, note keys)
//   - `NUMBEROFKEYBOARDINPUTS
//   - prefix byte constants (E0, F0, E1)
//   - prefix FSM state encodings
//  Sub-module scancode_to_key_index: combinational.
//   - inputs: {extended, byte}
//   - outputs: {hit, index}
//   - normal table: 29->`keySpacebar, 5D->`keyBackslash, 2D->`keyR, piano row codes.
//   - extended table: arrow keys only.
//  Top level: prefix FSM, timeout counter, vector register, pulse logic.
// TESTING
//  1. Reset released -> all outputs 0; byte 29 -> inputStateStorage[`keySpacebar]=1 and keyPressPulse[`keySpacebar]=1, both on the next cycle.
//  2. Bytes 2D,2D,2D then F0,2D -> one press pulse; bit `keyR stays 1 through the repeats; one release pulse; bit `keyR=0.
//  3. Bytes 29,5D then F0,29 -> both bits set; after the break only the `keyBackslash bit is 1; no release pulse for the held backslash.
//  4. Bytes E0,75 then E0,F0,75 -> the extended up-arrow bit sets, then clears; normal-table index for 75 is untouched.
//  5. Byte F0, then idle TIMEOUT_CYCLES -> FSM back in IDLE; a following 29 is treated as a make (bit sets).
//  6. Unmapped byte 0x7E -> unknownCode one cycle, vector unchanged; resetn pulsed low between F0 and 29 -> vector 0, and 29 afterwards is a make.

Source files
------------

// File: rtl/keyboard_state_decoder_pkg.sv
// keyboard_state_decoder_pkg: key indices, PS/2 prefix bytes and prefix FSM states
// shared by the scancode decoder and its users.
package keyboard_state_decoder_pkg;
    localparam int NUM_KEYS      = 15;
    localparam int KEY_W         = $clog2(NUM_KEYS);
    localparam int KEY_NOTE_BASE = 0;
    localparam int KEY_SPACEBAR  = 8;
    localparam int KEY_BACKSLASH = 9;
    localparam int KEY_R         = 10;
    localparam int KEY_UP        = 11;
    localparam int KEY_DOWN      = 12;
    localparam int KEY_LEFT      = 13;
    localparam int KEY_RIGHT     = 14;
    localparam logic [7:0] BYTE_EXT   = 8'hE0;
    localparam logic [7:0] BYTE_BRK   = 8'hF0;
    localparam logic [7:0] BYTE_PAUSE = 8'hE1;
    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} prefix_state_t;
    // Status/ack bytes and the Pause prefix never touch the FSM or the key vector
    function automatic logic is_ignored(input logic [7:0] b);
        return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, BYTE_PAUSE};
    endfunction
endpackage

// File: rtl/keyboard_state_decoder_if.sv
// keyboard_state_decoder_if: byte stream from the PS/2 receiver and the decoded
// key vector/pulses toward MasterFSM and the audio datapath.
interface keyboard_state_decoder_if;
    import keyboard_state_decoder_pkg::*;
    logic                ps2ByteValid;
    logic [7:0]          ps2Byte;
    logic [NUM_KEYS-1:0] inputStateStorage;
    logic [NUM_KEYS-1:0] keyPressPulse;
    logic [NUM_KEYS-1:0] keyReleasePulse;
    logic                unknownCode;
    modport master (output ps2ByteValid, ps2Byte,
                    input  inputStateStorage, keyPressPulse, keyReleasePulse, unknownCode);
    modport slave  (input  ps2ByteValid, ps2Byte,
                    output inputStateStorage, keyPressPulse, keyReleasePulse, unknownCode);
endinterface

// File: rtl/keyboard_state_decoder_scancode_to_key_index.sv
// scancode_to_key_index: combinational Set-2 scancode lookup; the extended table
// holds the arrow keys only, the normal table the piano row and control keys.
module scancode_to_key_index
    import keyboard_state_decoder_pkg::*;
(
    input  logic             i_extended,
    input  logic [7:0]       i_byte,
    output logic             o_hit,
    output logic [KEY_W-1:0] o_index
);
    always_comb begin
        o_hit   = 1'b1;
        o_index = '0;
        if (i_extended)
            case (i_byte)
                8'h75:   o_index = KEY_W'(KEY_UP);
                8'h72:   o_index = KEY_W'(KEY_DOWN);
                8'h6B:   o_index = KEY_W'(KEY_LEFT);
                8'h74:   o_index = KEY_W'(KEY_RIGHT);
                default: o_hit   = 1'b0;
            endcase
        else
            case (i_byte)
                8'h1C:   o_index = KEY_W'(KEY_NOTE_BASE + 0);
                8'h1B:   o_index = KEY_W'(KEY_NOTE_BASE + 1);
                8'h23:   o_index = KEY_W'(KEY_NOTE_BASE + 2);
                8'h2B:   o_index = KEY_W'(KEY_NOTE_BASE + 3);
                8'h34:   o_index = KEY_W'(KEY_NOTE_BASE + 4);
                8'h33:   o_index = KEY_W'(KEY_NOTE_BASE + 5);
                8'h3B:   o_index = KEY_W'(KEY_NOTE_BASE + 6);
                8'h42:   o_index = KEY_W'(KEY_NOTE_BASE + 7);
                8'h29:   o_index = KEY_W'(KEY_SPACEBAR);
                8'h5D:   o_index = KEY_W'(KEY_BACKSLASH);
                8'h2D:   o_index = KEY_W'(KEY_R);
                default: o_hit   = 1'b0;
            endcase
    end
endmodule

// File: rtl/keyboard_state_decoder.sv
// keyboard_state_decoder: PS/2 Set-2 byte stream -> held-key vector plus one-cycle
// press/release/unknown pulses; stale prefixes are dropped after TIMEOUT_CYCLES.
module keyboard_state_decoder
    import keyboard_state_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input logic                     clk,
    input logic                     resetn,
    keyboard_state_decoder_if.slave ps2
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    prefix_state_t       r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_KEYS-1:0] r_keys, r_press, r_rel, w_mask;
    logic                r_unk, w_code, w_hit, w_expire, w_ext, w_brk;
    logic [KEY_W-1:0]    w_idx;

    assign w_ext    = r_state == S_EXT || r_state == S_EXTBRK;
    assign w_brk    = r_state == S_BRK || r_state == S_EXTBRK;
    assign w_expire = !ps2.ps2ByteValid && r_state != S_IDLE && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign w_mask   = {{(NUM_KEYS-1){1'b0}}, 1'b1} << w_idx;

    scancode_to_key_index u_lookup (
        .i_extended (w_ext),
        .i_byte     (ps2.ps2Byte),
        .o_hit      (w_hit),
        .o_index    (w_idx)
    );

    // w_code marks a byte that completes a code and must be looked up
    always_comb begin
        w_next = r_state;
        w_code = 1'b0;
        if (ps2.ps2ByteValid && !is_ignored(ps2.ps2Byte)) begin
            w_next = S_IDLE;
            w_code = 1'b1;
            if (r_state == S_IDLE && ps2.ps2Byte == BYTE_EXT) begin
                w_next = S_EXT;
                w_code = 1'b0;
            end else if (ps2.ps2Byte == BYTE_BRK && !w_brk) begin
                w_next = r_state == S_IDLE ? S_BRK : S_EXTBRK;
                w_code = 1'b0;
            end else if (w_brk && (ps2.ps2Byte == BYTE_EXT || (ps2.ps2Byte == BYTE_BRK && r_state == S_EXTBRK)))
                w_code = 1'b0;
        end else if (w_expire)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_keys  <= '0;
            r_press <= '0;
            r_rel   <= '0;
            r_unk   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (ps2.ps2ByteValid || r_state == S_IDLE || w_expire) ? '0 : r_cnt + 1'b1;
            r_press <= (w_code && w_hit && !w_brk) ? w_mask & ~r_keys : '0;
            r_rel   <= (w_code && w_hit && w_brk) ? w_mask & r_keys : '0;
            r_unk   <= w_code && !w_hit;
            if (w_code && w_hit)
                r_keys <= w_brk ? r_keys & ~w_mask : r_keys | w_mask;
        end
    end

    assign ps2.inputStateStorage = r_keys;
    assign ps2.keyPressPulse     = r_press;
    assign ps2.keyReleasePulse   = r_rel;
    assign ps2.unknownCode       = r_unk;
endmodule

// File: tb/tb_keyboard_state_decoder.sv
// tb_keyboard_state_decoder: table-driven byte vectors plus timeout/reset sequences;
// expectations are queued when a byte is driven and checked when the DUT answers.
module tb_keyboard_state_decoder;
    localparam int T = 16;
    localparam logic [14:0] Z  = 15'h0000;
    localparam logic [14:0] N0 = 15'h0001;
    localparam logic [14:0] SP = 15'h0100;
    localparam logic [14:0] BS = 15'h0200;
    localparam logic [14:0] R  = 15'h0400;
    localparam logic [14:0] UP = 15'h0800;

    typedef struct {
        logic [7:0]  b;
        logic [14:0] keys, press, rel;
        logic        unk;
    } vec_t;
    typedef struct {
        logic [14:0] keys, press, rel;
        logic        unk;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic prev_v = 1'b0;
    exp_t q[$];
    vec_t tab[$];

    keyboard_state_decoder_if bus();
    keyboard_state_decoder #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .resetn(resetn), .ps2(bus));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [45:0] got, input logic [45:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got keys=%h press=%h rel=%h unk=%b want keys=%h press=%h rel=%h unk=%b",
                     nm, got[45:31], got[30:16], got[15:1], got[0], want[45:31], want[30:16], want[15:1], want[0]);
        end
    endtask

    function automatic logic [45:0] outs();
        return {bus.inputStateStorage, bus.keyPressPulse, bus.keyReleasePulse, bus.unknownCode};
    endfunction

    // Strobe cycle and the following idle cycle each have a queued expectation
    always @(posedge clk) begin
        automatic logic cur = bus.ps2ByteValid;
        automatic logic pend = cur || prev_v;
        exp_t e;
        prev_v = cur;
        if (pend) begin
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow got output with no expectation");
            end else begin
                e = q.pop_front();
                check(e.name, outs(), {e.keys, e.press, e.rel, e.unk});
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic [14:0] k, p, r, input logic u, input string nm);
        @(negedge clk);
        bus.ps2ByteValid = 1'b1;
        bus.ps2Byte = b;
        q.push_back('{keys: k, press: p, rel: r, unk: u, name: nm});
        @(negedge clk);
        bus.ps2ByteValid = 1'b0;
        q.push_back('{keys: k, press: Z, rel: Z, unk: 1'b0, name: {nm, "_idle"}});
    endtask

    initial begin
        tab.push_back('{8'h29, SP,      SP, Z,  1'b0});
        tab.push_back('{8'h2D, SP | R,  R,  Z,  1'b0});
        tab.push_back('{8'h2D, SP | R,  Z,  Z,  1'b0});
        tab.push_back('{8'h2D, SP | R,  Z,  Z,  1'b0});
        tab.push_back('{8'hF0, SP | R,  Z,  Z,  1'b0});
        tab.push_back('{8'h2D, SP,      Z,  R,  1'b0});
        tab.push_back('{8'h5D, SP | BS, BS, Z,  1'b0});
        tab.push_back('{8'hF0, SP | BS, Z,  Z,  1'b0});
        tab.push_back('{8'h29, BS,      Z,  SP, 1'b0});
        tab.push_back('{8'hF0, BS,      Z,  Z,  1'b0});
        tab.push_back('{8'h29, BS,      Z,  Z,  1'b0});
        tab.push_back('{8'hE0, BS,      Z,  Z,  1'b0});
        tab.push_back('{8'h75, BS | UP, UP, Z,  1'b0});
        tab.push_back('{8'hE0, BS | UP, Z,  Z,  1'b0});
        tab.push_back('{8'hF0, BS | UP, Z,  Z,  1'b0});
        tab.push_back('{8'h75, BS,      Z,  UP, 1'b0});
        tab.push_back('{8'h75, BS,      Z,  Z,  1'b1});
        tab.push_back('{8'h7E, BS,      Z,  Z,  1'b1});
        tab.push_back('{8'hAA, BS,      Z,  Z,  1'b0});
        tab.push_back('{8'hE1, BS,      Z,  Z,  1'b0});
        tab.push_back('{8'hF0, BS,      Z,  Z,  1'b0});
        tab.push_back('{8'hE1, BS,      Z,  Z,  1'b0});
        tab.push_back('{8'h5D, Z,       Z,  BS, 1'b0});
        tab.push_back('{8'hF0, Z,       Z,  Z,  1'b0});
        tab.push_back('{8'hE0, Z,       Z,  Z,  1'b0});
        tab.push_back('{8'h29, SP,      SP, Z,  1'b0});
        tab.push_back('{8'hE0, SP,      Z,  Z,  1'b0});
        tab.push_back('{8'hF0, SP,      Z,  Z,  1'b0});
        tab.push_back('{8'hF0, SP,      Z,  Z,  1'b0});
        tab.push_back('{8'h6B, SP,      Z,  Z,  1'b1});
        tab.push_back('{8'h1C, SP | N0, N0, Z,  1'b0});
        tab.push_back('{8'hF0, SP | N0, Z,  Z,  1'b0});
        tab.push_back('{8'h1C, SP,      Z,  N0, 1'b0});

        bus.ps2ByteValid = 1'b0;
        bus.ps2Byte = 8'h00;
        repeat (3) @(negedge clk);
        check("in_reset", outs(), 46'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("after_reset", outs(), 46'd0);

        foreach (tab[i])
            send(tab[i].b, tab[i].keys, tab[i].press, tab[i].rel, tab[i].unk, $sformatf("vec%0d", i));

        // Byte landing in the expiry cycle is still decoded with the break prefix
        send(8'hF0, SP, Z, Z, 1'b0, "expiry_f0");
        repeat (T - 2) @(negedge clk);
        send(8'h29, Z, Z, SP, 1'b0, "expiry_break");
        // One cycle later the prefix has been dropped, so the code is a make
        send(8'hF0, Z, Z, Z, 1'b0, "timeout_f0");
        repeat (T - 1) @(negedge clk);
        send(8'h29, SP, SP, Z, 1'b0, "timeout_make");

        send(8'hF0, SP, Z, Z, 1'b0, "prereset_f0");
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("async_reset", outs(), 46'd0);
        @(negedge clk);
        resetn = 1'b1;
        send(8'h29, SP, SP, Z, 1'b0, "post_reset_make");

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
